// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready register-bus target among NUM_REQ masters.
// Define REG_BUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module reg_bus_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0]              req_write_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic [DATA_WIDTH-1:0]           req_rdata_o,
  output logic                            req_error_o,
  output logic [ADDR_WIDTH-1:0]           out_addr_o,
  output logic                            out_write_o,
  output logic [DATA_WIDTH-1:0]           out_wdata_o,
  output logic [DATA_WIDTH/8-1:0]         out_wstrb_o,
  output logic                            out_valid_o,
  input  logic [DATA_WIDTH-1:0]           out_rdata_i,
  input  logic                            out_error_i,
  input  logic                            out_ready_i
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  typedef enum logic {StIdle, StLocked} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
  logic [IdxW-1:0]   rr_ptr;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   sel_idx;
  logic [IdxW-1:0]   sel_idx_inc;
  logic              any_valid;
  logic              locked;
  logic              fwd_valid;

`ifdef REG_BUS_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  assign rr_ptr = rr_ptr_q;
`endif

  assign any_valid = |req_valid_i;
  assign locked    = (state_q == StLocked);

  // First set valid at or above the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    logic found;
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      int unsigned cand;
      cand = 32'(rr_ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid_i[IdxW'(cand)]) begin
        found   = 1'b1;
        win_idx = IdxW'(cand);
      end
    end
  end

  assign sel_idx     = locked ? lock_idx_q : win_idx;
  assign fwd_valid   = locked ? req_valid_i[lock_idx_q] : any_valid;
  assign sel_idx_inc = (32'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + IdxW'(1);

  always_comb begin
    out_addr_o  = '0;
    out_write_o = 1'b0;
    out_wdata_o = '0;
    out_wstrb_o = '0;
    req_ready_o = '0;
    if (locked || any_valid) begin
      out_addr_o  = req_addr_i[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
      out_write_o = req_write_i[sel_idx];
      out_wdata_o = req_wdata_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
      out_wstrb_o = req_wstrb_i[sel_idx*StrbW +: StrbW];
    end
    req_ready_o[sel_idx] = fwd_valid & out_ready_i;
  end

  assign out_valid_o = fwd_valid;
  assign req_rdata_o = out_rdata_i;
  assign req_error_o = out_error_i;

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
`ifndef REG_BUS_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
    if (fwd_valid && out_ready_i) rr_ptr_d = sel_idx_inc;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_valid && !out_ready_i) begin
          state_d    = StLocked;
          lock_idx_d = win_idx;
        end
      end
      StLocked: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      lock_idx_q <= '0;
`ifndef REG_BUS_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
`ifndef REG_BUS_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter with three masters.
module tb_reg_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_write;
  logic [N*DW-1:0] req_wdata;
  logic [N*4-1:0]  req_wstrb;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   req_rdata;
  logic            req_error;
  logic [AW-1:0]   out_addr;
  logic            out_write;
  logic [DW-1:0]   out_wdata;
  logic [3:0]      out_wstrb;
  logic            out_valid;
  logic [DW-1:0]   out_rdata;
  logic            out_error;
  logic            out_ready;

  reg_bus_arbiter #(
    .NUM_REQ   (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_addr_i (req_addr),
    .req_write_i(req_write),
    .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_rdata_o(req_rdata),
    .req_error_o(req_error),
    .out_addr_o (out_addr),
    .out_write_o(out_write),
    .out_wdata_o(out_wdata),
    .out_wstrb_o(out_wstrb),
    .out_valid_o(out_valid),
    .out_rdata_i(out_rdata),
    .out_error_i(out_error),
    .out_ready_i(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        write;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int idx, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic w, input logic [31:0] rd,
                      input logic e);
    exp_t x;
    x.idx = idx; x.addr = a; x.wdata = d; x.wstrb = s; x.write = w; x.rdata = rd; x.err = e;
    sb.push_back(x);
  endtask

  task automatic set_master(input int i, input logic v, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    req_valid[i]          = v;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*4 +: 4]   = s;
  endtask

  // Compare a completed handshake against the oldest expected transaction.
  task automatic observe();
    exp_t        e;
    logic [N-1:0] g;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        g = 3'b001 << e.idx;
        check("grant", 64'(req_ready), 64'(g));
        check("addr", 64'(out_addr), 64'(e.addr));
        check("wdata", 64'(out_wdata), 64'(e.wdata));
        check("wstrb", 64'(out_wstrb), 64'(e.wstrb));
        check("write", 64'(out_write), 64'(e.write));
        check("rdata", 64'(req_rdata), 64'(e.rdata));
        check("error", 64'(req_error), 64'(e.err));
      end
    end else begin
      check("no_ready", 64'(req_ready), 64'd0);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    out_rdata = '0;
    out_error = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;
    req_wstrb = '0;
    req_valid = '0;
    out_rdata = '0;
    out_error = 1'b0;
    out_ready = 1'b0;

    // Reset and idle outputs.
    reset_dut();
    out_rdata = 32'h5555_AAAA;
    out_error = 1'b1;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_addr", 64'(out_addr), 64'd0);
    check("rst_wdata", 64'(out_wdata), 64'd0);
    check("rst_rdata_pass", 64'(req_rdata), 64'h5555_AAAA);
    check("rst_error_pass", 64'(req_error), 64'd1);
`ifndef REG_BUS_ARB_FIXED_PRIO_EN
    check("rst_ptr", 64'(dut.rr_ptr_q), 64'd0);
`endif
    out_rdata = '0;
    out_error = 1'b0;

    // Single master, always-ready target.
    @(negedge clk);
    push(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 1'b0);
    set_master(1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    out_ready = 1'b1;
    #1;
    check("single_ready", 64'(req_ready), 64'b010);
    observe();
    @(negedge clk);
    req_valid = '0;
    #1;
    check("single_idle_valid", 64'(out_valid), 64'd0);
`ifndef REG_BUS_ARB_FIXED_PRIO_EN
    check("single_ptr", 64'(dut.rr_ptr_q), 64'd2);
`endif

    // All masters requesting continuously.
    reset_dut();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      set_master(i, 1'b1, 1'b1, 32'h100 + 32'(i), 32'hA000_0000 + 32'(i), 4'h3);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
`ifdef REG_BUS_ARB_FIXED_PRIO_EN
      push(0, 32'h100, 32'hA000_0000, 4'h3, 1'b1, 32'h0, 1'b0);
`else
      push(k % 3, 32'h100 + 32'(k % 3), 32'hA000_0000 + 32'(k % 3), 4'h3, 1'b1, 32'h0, 1'b0);
`endif
    end
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check("all_onehot", 64'($onehot(req_ready)), 64'd1);
      observe();
    end
    @(negedge clk);
    req_valid = '0;

    // Lock under stall, late competitor on master 2.
    reset_dut();
    push(0, 32'hA0, 32'h0000_00A0, 4'h1, 1'b0, 32'h1234, 1'b0);
    push(2, 32'hC0, 32'h0000_00C0, 4'h8, 1'b1, 32'h1234, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) set_master(0, 1'b1, 1'b0, 32'hA0, 32'h0000_00A0, 4'h1);
      if (c == 2) set_master(2, 1'b1, 1'b1, 32'hC0, 32'h0000_00C0, 4'h8);
      out_ready = 1'b0;
      #1;
      check("stall_addr", 64'(out_addr), 64'hA0);
      check("stall_valid", 64'(out_valid), 64'd1);
      observe();
    end
    @(negedge clk);
    out_ready = 1'b1;
    out_rdata = 32'h1234;
    #1;
    check("stall_done_ready", 64'(req_ready), 64'b001);
    observe();
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    observe();
    @(negedge clk);
    req_valid = '0;
    out_rdata = '0;

    // Error propagation, then reset while locked.
    reset_dut();
    push(1, 32'h44, 32'h0, 4'h0, 1'b0, 32'h0BAD, 1'b1);
    @(negedge clk);
    set_master(1, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    out_ready = 1'b1;
    out_rdata = 32'h0BAD;
    out_error = 1'b1;
    #1;
    check("err_seen", 64'(req_error), 64'd1);
    observe();
    @(negedge clk);
    req_valid[1] = 1'b0;
    set_master(2, 1'b1, 1'b0, 32'h88, 32'h0, 4'h0);
    out_ready = 1'b0;
    out_error = 1'b0;
    #1;
    check("lock_valid", 64'(out_valid), 64'd1);
    observe();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("locked_addr", 64'(out_addr), 64'h88);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    #1;
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_lock", 64'(dut.lock_idx_q), 64'd0);
`ifndef REG_BUS_ARB_FIXED_PRIO_EN
    check("post_rst_ptr", 64'(dut.rr_ptr_q), 64'd0);
`endif
    // Pointer back at 0: master 1 must beat master 2.
    @(negedge clk);
    push(1, 32'h44, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    set_master(1, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    set_master(2, 1'b1, 1'b0, 32'h88, 32'h0, 4'h0);
    out_ready = 1'b1;
    out_rdata = '0;
    #1;
    observe();
    @(negedge clk);
    push(2, 32'h88, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    req_valid[1] = 1'b0;
    #1;
    observe();
    @(negedge clk);
    req_valid = '0;

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
